// File: rtl/draw_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_sprite_pkg
// Description : Shared widths, defaults and blink-state encoding for draw_sprite.
// Revision    : 1.0 - initial release
// ============================================================================
package draw_sprite_pkg;

   localparam int c_TIM_W  = 11;
   localparam int c_RGB_W  = 12;
   localparam int c_ROM_AW = 12;
   localparam int c_POS_W  = 12;

   localparam int                 c_SPRITE_W_DEF     = 64;
   localparam int                 c_SPRITE_H_DEF     = 64;
   localparam logic [c_RGB_W-1:0] c_KEY_COLOR_DEF    = 12'h0F0;
   localparam int                 c_FLASH_FRAMES_DEF = 16;

   typedef enum logic [0:0] {
      BLINK_IDLE  = 1'b0,
      BLINK_FLASH = 1'b1
   } blink_state_t;

endpackage
`default_nettype wire

// File: rtl/draw_sprite_delay.sv
`default_nettype none
// ============================================================================
// Module      : draw_sprite_delay
// Description : Resettable shift-register delay of a WIDTH-bit bus by CLK_DEL clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_sprite_delay #(
   parameter int WIDTH   = 8,
   parameter int CLK_DEL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);

   logic [WIDTH-1:0] r_pipe [CLK_DEL];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CLK_DEL; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= i_din;
         for (int i = 1; i < CLK_DEL; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_dout = r_pipe[CLK_DEL-1];

endmodule
`default_nettype wire

// File: rtl/draw_sprite.sv
`default_nettype none
// ============================================================================
// Module      : draw_sprite
// Description : Overlays a ROM sprite with key-colour transparency and hit blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_sprite
   import draw_sprite_pkg::*;
#(
   parameter int                 SPRITE_W     = c_SPRITE_W_DEF,
   parameter int                 SPRITE_H     = c_SPRITE_H_DEF,
   parameter logic [c_RGB_W-1:0] KEY_COLOR    = c_KEY_COLOR_DEF,
   parameter int                 FLASH_FRAMES = c_FLASH_FRAMES_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [c_TIM_W-1:0]  hcount_in,
   input  logic [c_TIM_W-1:0]  vcount_in,
   input  logic                hsync_in,
   input  logic                vsync_in,
   input  logic                hblnk_in,
   input  logic                vblnk_in,
   input  logic [c_RGB_W-1:0]  rgb_in,
   input  logic [c_POS_W-1:0]  xpos,
   input  logic [c_POS_W-1:0]  ypos,
   input  logic                hit,
   input  logic [c_RGB_W-1:0]  rom_rgb,
   output logic [c_ROM_AW-1:0] rom_addr,
   output logic [c_TIM_W-1:0]  hcount_out,
   output logic [c_TIM_W-1:0]  vcount_out,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                hblnk_out,
   output logic                vblnk_out,
   output logic [c_RGB_W-1:0]  rgb_out
);

   localparam int c_XB       = $clog2(SPRITE_W);
   localparam int c_YB       = $clog2(SPRITE_H);
   localparam int c_CNT_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam int c_BUS_W    = 2*c_TIM_W + 4 + c_RGB_W;
   // The output register below supplies the third cycle of delay.
   localparam int c_PIPE_DEL = 2;

   logic                r_vsync_prev;
   logic                w_vs_rise;
   logic [c_POS_W-1:0]  r_xpos_l, r_ypos_l;
   logic [c_POS_W-1:0]  w_h, w_v, w_dx, w_dy;
   logic                w_in_sprite;
   logic                w_visible;
   logic                r_insp1, r_vis1, r_show2;

   blink_state_t        r_state, w_state_nxt;
   logic [c_CNT_W-1:0]  r_frame_cnt, w_frame_cnt_nxt;

   logic [c_BUS_W-1:0]  w_bus_d2;
   logic [c_TIM_W-1:0]  w_hcount_d2, w_vcount_d2;
   logic                w_hsync_d2, w_vsync_d2, w_hblnk_d2, w_vblnk_d2;
   logic [c_RGB_W-1:0]  w_rgb_d2;

   assign w_vs_rise = vsync_in & ~r_vsync_prev;

   assign w_h  = {1'b0, hcount_in};
   assign w_v  = {1'b0, vcount_in};
   assign w_dx = w_h - r_xpos_l;
   assign w_dy = w_v - r_ypos_l;

   // Extra MSB on the size compare keeps SPRITE_W/H up to 4096 representable.
   assign w_in_sprite = (w_h >= r_xpos_l) && ({1'b0, w_dx} < 13'(SPRITE_W)) &&
                        (w_v >= r_ypos_l) && ({1'b0, w_dy} < 13'(SPRITE_H));

   assign w_visible = (r_state == BLINK_IDLE) || !r_frame_cnt[0];

   always_comb begin
      w_state_nxt     = r_state;
      w_frame_cnt_nxt = r_frame_cnt;
      case (r_state)
         BLINK_IDLE: begin
            if (hit) begin
               w_state_nxt     = BLINK_FLASH;
               w_frame_cnt_nxt = '0;
            end
         end
         BLINK_FLASH: begin
            if (hit) begin
               w_frame_cnt_nxt = '0;
            end else if (w_vs_rise) begin
               if (r_frame_cnt == c_CNT_W'(FLASH_FRAMES-1)) begin
                  w_state_nxt     = BLINK_IDLE;
                  w_frame_cnt_nxt = '0;
               end else begin
                  w_frame_cnt_nxt = r_frame_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt     = BLINK_IDLE;
            w_frame_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= BLINK_IDLE;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
      end
   end

   // Stage 1 and 2: position latch, ROM address and the per-pixel draw decision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vsync_prev <= 1'b0;
         r_xpos_l     <= '0;
         r_ypos_l     <= '0;
         rom_addr     <= '0;
         r_insp1      <= 1'b0;
         r_vis1       <= 1'b0;
         r_show2      <= 1'b0;
      end else begin
         r_vsync_prev <= vsync_in;
         if (w_vs_rise) begin
            r_xpos_l <= xpos;
            r_ypos_l <= ypos;
         end
         rom_addr <= c_ROM_AW'({w_dy[c_YB-1:0], w_dx[c_XB-1:0]});
         r_insp1  <= w_in_sprite;
         r_vis1   <= w_visible;
         r_show2  <= r_insp1 & r_vis1;
      end
   end

   draw_sprite_delay #(
      .WIDTH   (c_BUS_W),
      .CLK_DEL (c_PIPE_DEL)
   ) u_timing_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in}),
      .o_dout (w_bus_d2)
   );

   assign {w_hcount_d2, w_vcount_d2, w_hsync_d2, w_vsync_d2,
           w_hblnk_d2, w_vblnk_d2, w_rgb_d2} = w_bus_d2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= w_hcount_d2;
         vcount_out <= w_vcount_d2;
         hsync_out  <= w_hsync_d2;
         vsync_out  <= w_vsync_d2;
         hblnk_out  <= w_hblnk_d2;
         vblnk_out  <= w_vblnk_d2;
         if (w_hblnk_d2 || w_vblnk_d2) begin
            rgb_out <= '0;
         end else if (r_show2 && (rom_rgb != KEY_COLOR)) begin
            rgb_out <= rom_rgb;
         end else begin
            rgb_out <= w_rgb_d2;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_sprite
// Description : Self-checking bench for draw_sprite with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_sprite;

   localparam int          FF  = 4;
   localparam int          SW  = 64;
   localparam int          SH  = 64;
   localparam logic [11:0] KEY = 12'h0F0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
   logic        hit = 1'b0;
   logic [11:0] rom_rgb = '0;
   logic [11:0] rom_addr;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   wire  [25:0] tim_out = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out};

   always #5 clk = ~clk;

   draw_sprite #(
      .SPRITE_W     (SW),
      .SPRITE_H     (SH),
      .KEY_COLOR    (KEY),
      .FLASH_FRAMES (FF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .hit        (hit),
      .rom_rgb    (rom_rgb),
      .rom_addr   (rom_addr),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   // Image ROM with one cycle of read latency.
   logic [11:0] mem [4096];
   always @(posedge clk) rom_rgb <= mem[rom_addr];

   // Reference model: one record per sampled pixel, newest at the front.
   typedef struct {
      logic [10:0] h, v;
      logic        hs, vs, hb, vb;
      logic [11:0] rgb;
      bit          show;
      logic [11:0] addr;
      logic [11:0] romv;
   } rec_t;

   rec_t        hist[$];
   int          m_xl, m_yl, m_frame;
   bit          m_prev_vs, m_flash;
   logic [11:0] exp_rgb, exp_addr;
   logic [25:0] exp_tim;
   int          errors = 0;
   int          checks = 0;

   task automatic step();
      rec_t r, e;
      int   dx, dy;
      @(posedge clk);
      if (!rst_n) begin
         r = '{default: '0};
         hist = {};
         repeat (3) hist.push_front(r);
         m_xl = 0; m_yl = 0; m_flash = 0; m_frame = 0; m_prev_vs = 0;
      end else begin
         hist[0].romv = mem[hist[0].addr];
         dx = int'(hcount_in) - m_xl;
         dy = int'(vcount_in) - m_yl;
         r.h = hcount_in; r.v = vcount_in;
         r.hs = hsync_in; r.vs = vsync_in; r.hb = hblnk_in; r.vb = vblnk_in;
         r.rgb = rgb_in;
         r.show = (dx >= 0 && dx < SW && dy >= 0 && dy < SH) && (!m_flash || (m_frame % 2 == 0));
         r.addr = 12'((dy & (SH-1)) * SW + (dx & (SW-1)));
         r.romv = '0;
         hist.push_front(r);
         if (hist.size() > 3) void'(hist.pop_back());
         if (hit) begin
            m_flash = 1; m_frame = 0;
         end else if (m_flash && vsync_in && !m_prev_vs) begin
            m_frame++;
            if (m_frame == FF) begin m_flash = 0; m_frame = 0; end
         end
         if (vsync_in && !m_prev_vs) begin m_xl = int'(xpos); m_yl = int'(ypos); end
         m_prev_vs = vsync_in;
      end
      e = hist[2];
      exp_addr = hist[0].addr;
      exp_tim  = {e.h, e.v, e.hs, e.vs, e.hb, e.vb};
      exp_rgb  = (e.hb || e.vb) ? 12'h000 : ((e.show && e.romv != KEY) ? e.romv : e.rgb);
      #1;
   endtask

   task automatic drive(input int h, input int v, input bit vs, input bit blank, input bit hv);
      hcount_in = 11'(h); vcount_in = 11'(v);
      vsync_in = vs; hsync_in = 1'($urandom_range(0, 1));
      hblnk_in = blank; vblnk_in = 1'b0;
      rgb_in = 12'($urandom); hit = hv;
   endtask

   task automatic pix3(input int h, input int v, output logic [11:0] bg, output logic [11:0] got);
      drive(h, v, 1'b0, 1'b0, 1'b0);
      bg = rgb_in;
      step(); step(); step();
      got = rgb_out;
   endtask

   task automatic latch(input int x, input int y);
      xpos = 12'(x); ypos = 12'(y);
      drive(0, 0, 1'b0, 1'b1, 1'b0); step();
      drive(0, 0, 1'b1, 1'b1, 1'b0); step();
      drive(0, 0, 1'b0, 1'b1, 1'b0); step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b1, 1'b0, 1'b1);
         step();
         checks++;
         if ({rgb_out, rom_addr, tim_out} !== 50'h0) begin
            errors++;
            $display("FAIL reset_zero got rgb=%h addr=%h tim=%h exp all zero", rgb_out, rom_addr, tim_out);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(int'($urandom_range(0, 200)), int'($urandom_range(0, 200)), 1'b0, 1'(i == 4), 1'b0);
         step();
         checks++;
         if ({rgb_out, rom_addr, tim_out} !== {exp_rgb, exp_addr, exp_tim}) begin
            errors++;
            $display("FAIL reset_model got rgb=%h addr=%h tim=%h exp rgb=%h addr=%h tim=%h",
                     rgb_out, rom_addr, tim_out, exp_rgb, exp_addr, exp_tim);
         end
      end
   endtask

   task automatic test_rom_addr();
      logic [11:0] bg;
      latch(100, 50);
      mem[12'h000] = 12'h123;
      mem[12'hFFF] = 12'h456;
      drive(100, 50, 1'b0, 1'b0, 1'b0); step();
      checks++;
      if (rom_addr !== 12'h000) begin
         errors++; $display("FAIL addr_corner0 got=%h exp=%h", rom_addr, 12'h000);
      end
      drive(163, 113, 1'b0, 1'b0, 1'b0); step();
      checks++;
      if (rom_addr !== 12'hFFF) begin
         errors++; $display("FAIL addr_cornerF got=%h exp=%h", rom_addr, 12'hFFF);
      end
      drive(164, 113, 1'b0, 1'b0, 1'b0); bg = rgb_in; step();
      checks++;
      if (rgb_out !== 12'h123) begin
         errors++; $display("FAIL rgb_corner0 got=%h exp=%h", rgb_out, 12'h123);
      end
      drive(164, 113, 1'b0, 1'b0, 1'b0); rgb_in = bg; step();
      checks++;
      if (rgb_out !== 12'h456) begin
         errors++; $display("FAIL rgb_cornerF got=%h exp=%h", rgb_out, 12'h456);
      end
      step();
      checks++;
      if (rgb_out !== bg) begin
         errors++; $display("FAIL rgb_past_right got=%h exp=%h", rgb_out, bg);
      end
   endtask

   task automatic test_key_color();
      logic [11:0] bg, got;
      mem[10*SW + 10] = KEY;
      mem[10*SW + 11] = 12'hF00;
      pix3(110, 60, bg, got);
      checks++;
      if (got !== bg) begin
         errors++; $display("FAIL key_transparent got=%h exp=%h", got, bg);
      end
      pix3(111, 60, bg, got);
      checks++;
      if (got !== 12'hF00) begin
         errors++; $display("FAIL key_opaque got=%h exp=%h", got, 12'hF00);
      end
      drive(111, 60, 1'b0, 1'b1, 1'b0); step(); step(); step();
      checks++;
      if (rgb_out !== 12'h000) begin
         errors++; $display("FAIL blank_black got=%h exp=%h", rgb_out, 12'h000);
      end
   endtask

   task automatic test_mid_frame();
      logic [11:0] bg, got;
      latch(0, 0);
      mem[5] = 12'hABC;
      xpos = 12'd200;
      pix3(5, 0, bg, got);
      checks++;
      if (got !== 12'hABC) begin
         errors++; $display("FAIL midframe_old_pos got=%h exp=%h", got, 12'hABC);
      end
      pix3(205, 0, bg, got);
      checks++;
      if (got !== bg) begin
         errors++; $display("FAIL midframe_new_early got=%h exp=%h", got, bg);
      end
      latch(200, 0);
      pix3(205, 0, bg, got);
      checks++;
      if (got !== 12'hABC) begin
         errors++; $display("FAIL midframe_new_pos got=%h exp=%h", got, 12'hABC);
      end
      pix3(5, 0, bg, got);
      checks++;
      if (got !== bg) begin
         errors++; $display("FAIL midframe_old_gone got=%h exp=%h", got, bg);
      end
   endtask

   task automatic test_blink();
      logic [11:0] bg, got;
      latch(100, 50);
      mem[10*SW + 10] = 12'h0AA;
      drive(0, 0, 1'b0, 1'b1, 1'b1); step();
      for (int f = 0; f < 6; f++) begin
         pix3(110, 60, bg, got);
         checks++;
         if (got !== ((f == 1 || f == 3) ? bg : 12'h0AA)) begin
            errors++;
            $display("FAIL blink_frame%0d got=%h exp=%h", f, got, (f == 1 || f == 3) ? bg : 12'h0AA);
         end
         latch(100, 50);
      end
      drive(0, 0, 1'b0, 1'b1, 1'b1); step();
      latch(100, 50); latch(100, 50);
      drive(0, 0, 1'b0, 1'b1, 1'b1); step();
      pix3(110, 60, bg, got);
      checks++;
      if (got !== 12'h0AA) begin
         errors++; $display("FAIL rehit_frame0 got=%h exp=%h", got, 12'h0AA);
      end
      latch(100, 50);
      pix3(110, 60, bg, got);
      checks++;
      if (got !== bg) begin
         errors++; $display("FAIL rehit_frame1 got=%h exp=%h", got, bg);
      end
      latch(100, 50); latch(100, 50);
      drive(0, 0, 1'b1, 1'b1, 1'b1); step();
      drive(0, 0, 1'b0, 1'b1, 1'b0); step();
      pix3(110, 60, bg, got);
      checks++;
      if (got !== 12'h0AA) begin
         errors++; $display("FAIL hit_on_end_frame0 got=%h exp=%h", got, 12'h0AA);
      end
      latch(100, 50);
      pix3(110, 60, bg, got);
      checks++;
      if (got !== bg) begin
         errors++; $display("FAIL hit_on_end_still_flash got=%h exp=%h", got, bg);
      end
      latch(100, 50); latch(100, 50); latch(100, 50);
      pix3(110, 60, bg, got);
      checks++;
      if (got !== 12'h0AA) begin
         errors++; $display("FAIL blink_back_idle got=%h exp=%h", got, 12'h0AA);
      end
   endtask

   task automatic test_no_wrap();
      logic [11:0] bg, got;
      latch(4090, 0);
      for (int h = 0; h <= 58; h++) begin
         drive(h, 5, 1'b0, 1'b0, 1'b0); step();
         checks++;
         if ({rgb_out, rom_addr, tim_out} !== {exp_rgb, exp_addr, exp_tim}) begin
            errors++;
            $display("FAIL nowrap_model h=%0d got rgb=%h addr=%h tim=%h exp rgb=%h addr=%h tim=%h",
                     h, rgb_out, rom_addr, tim_out, exp_rgb, exp_addr, exp_tim);
         end
      end
      for (int h = 0; h <= 58; h += 29) begin
         pix3(h, 5, bg, got);
         checks++;
         if (got !== bg) begin
            errors++; $display("FAIL nowrap_h%0d got=%h exp=%h", h, got, bg);
         end
      end
   endtask

   task automatic test_random();
      bit vs = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) vs = ~vs;
         if ($urandom_range(0, 99) == 0) begin
            xpos = 12'($urandom_range(0, 300)); ypos = 12'($urandom_range(0, 200));
         end
         drive(int'($urandom_range(0, 400)), int'($urandom_range(0, 300)), vs,
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 59) == 0));
         vblnk_in = 1'($urandom_range(0, 15) == 0);
         step();
         checks++;
         if ({rgb_out, rom_addr, tim_out} !== {exp_rgb, exp_addr, exp_tim}) begin
            errors++;
            $display("FAIL random_model i=%0d got rgb=%h addr=%h tim=%h exp rgb=%h addr=%h tim=%h",
                     i, rgb_out, rom_addr, tim_out, exp_rgb, exp_addr, exp_tim);
         end
      end
   endtask

   task automatic test_reset_mid_flash();
      logic [11:0] bg, got;
      mem[3*SW + 3] = 12'h5A5;
      latch(300, 300);
      drive(0, 0, 1'b0, 1'b1, 1'b1); step();
      latch(300, 300);
      drive(320, 310, 1'b0, 1'b0, 1'b0); step();
      drive(321, 310, 1'b0, 1'b0, 1'b0); step();
      rst_n = 1'b0;
      drive(322, 310, 1'b0, 1'b0, 1'b0); step();
      checks++;
      if ({rgb_out, rom_addr, tim_out} !== 50'h0) begin
         errors++;
         $display("FAIL midflash_reset got rgb=%h addr=%h tim=%h exp all zero", rgb_out, rom_addr, tim_out);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(int'($urandom_range(0, 80)), int'($urandom_range(0, 80)), 1'b0, 1'b0, 1'b0);
         step();
         checks++;
         if ({rgb_out, rom_addr, tim_out} !== {exp_rgb, exp_addr, exp_tim}) begin
            errors++;
            $display("FAIL midflash_resume got rgb=%h addr=%h tim=%h exp rgb=%h addr=%h tim=%h",
                     rgb_out, rom_addr, tim_out, exp_rgb, exp_addr, exp_tim);
         end
      end
      pix3(3, 3, bg, got);
      checks++;
      if (got !== 12'h5A5) begin
         errors++; $display("FAIL midflash_origin_idle got=%h exp=%h", got, 12'h5A5);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
      end
      test_reset();
      test_rom_addr();
      test_key_color();
      test_mid_frame();
      test_blink();
      test_no_wrap();
      test_random();
      test_reset_mid_flash();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/draw_sprite.md
DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 SHALL have parameter SPRITE_W, default 64, meaning sprite width in pixels (power of two; ROM x-address bits = log2).
REQ-002 SHALL have parameter SPRITE_H, default 64, meaning sprite height in pixels (power of two; ROM y-address bits = log2).
REQ-003 SHALL have parameter KEY_COLOR, default 12'h0F0, meaning transparent colour in ROM data.
REQ-004 SHALL have parameter FLASH_FRAMES, default 16, meaning frames of blinking after a hit.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  pixel clock, only clock
- rst_n  in  1  synchronous, active-low reset
- hcount_in  in  11  horizontal pixel count
- vcount_in  in  11  vertical line count
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing
- rgb_in  in  12  background pixel
- xpos, ypos  in  12  sprite top-left corner, unsigned
- hit  in  1  single-cycle pulse, starts blinking
- rom_rgb  in  12  image ROM data, valid 1 cycle after rom_addr
- rom_addr  out  12  {y[5:0], x[5:0]} into image ROM
- hcount_out, vcount_out  out  11  delayed counts
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited pixel

Function
REQ-006 All outputs SHALL be registered; every *_out SHALL equal the matching *_in delayed by exactly 3 clk cycles.
REQ-007 Cycle n+1: rom_addr SHALL be registered as {(vcount_in-ypos_l)[5:0], (hcount_in-xpos_l)[5:0]}; ROM data arrives cycle n+2; rgb_out registered at edge n+3.
REQ-008 Pixel in_sprite SHALL be true iff hcount_in >= xpos_l, hcount_in-xpos_l < SPRITE_W, vcount_in >= ypos_l, vcount_in-ypos_l < SPRITE_H; comparisons in 12-bit unsigned, no wrap-around hits.
REQ-009 in_sprite SHALL be carried through 2 pipeline stages aligned with rom_rgb.
REQ-010 rgb_out SHALL be rom_rgb when in_sprite, not blanked (hblnk|vblnk delayed), visible, and rom_rgb != KEY_COLOR; else rgb_in delayed 3 cycles; during blanking rgb_out SHALL be 12'h000.
REQ-011 xpos_l/ypos_l SHALL load xpos/ypos only on the clk after a vsync_in rising edge (0->1 detected against a registered copy); mid-frame changes SHALL NOT affect the current frame.
REQ-012 Blink FSM states: IDLE, FLASH. IDLE: visible=1. hit in IDLE -> FLASH, frame_cnt=0.
REQ-013 In FLASH: frame_cnt increments on each vsync_in rising edge; visible = ~frame_cnt[0]; when frame_cnt reaches FLASH_FRAMES-1 and a vsync rising edge occurs -> IDLE.
REQ-014 hit in FLASH SHALL restart frame_cnt to 0; hit coincident with the terminating vsync edge SHALL keep FLASH with frame_cnt=0 (hit has priority).
REQ-015 visible SHALL be sampled in stage 1 with in_sprite so a frame boundary never splits a pixel's decision.

Reset
REQ-016 When rst_n=0 at a clk edge: all *_out, rgb_out, rom_addr = 0; xpos_l, ypos_l = 0; FSM = IDLE; frame_cnt = 0; pipeline valid/in_sprite bits = 0.
REQ-017 Reset mid-frame or mid-FLASH SHALL take effect on that edge; output resumes with latency 3 after rst_n=1, sprite at (0,0) until next vsync edge.

Structure
REQ-018 Shared header/package SHALL hold timing widths (11), RGB width (12), ROM address width (12), SPRITE_W/H defaults, KEY_COLOR default.
REQ-019 Timing delay SHALL be a sub-module delay (parameters WIDTH, CLK_DEL), instanced for the 3-cycle bus {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}.
REQ-020 Blink FSM SHALL use two-process style (state register + next-state logic).

Verification
REQ-021 xpos=100, ypos=50 latched; hcount=100, vcount=50 -> rom_addr=12'h000 at n+1; hcount=163, vcount=113 -> rom_addr=12'hFFF; hcount=164 -> rgb_out = background.
REQ-022 rom_rgb=KEY_COLOR inside sprite -> rgb_out equals rgb_in from 3 cycles earlier; rom_rgb=12'hF00 -> rgb_out=12'hF00 at n+3.
REQ-023 xpos changed 0->200 mid-frame -> sprite stays at 0 until after next vsync rising edge, then at 200.
REQ-024 hit pulse, FLASH_FRAMES=4 -> sprite hidden in frames 1,3, shown in 0,2, IDLE after 4th vsync edge; second hit in frame 2 -> count restarts.
REQ-025 xpos=4090 -> no sprite pixels drawn at hcount 0..58 (no wrap).
REQ-026 rst_n=0 during FLASH mid-line -> all outputs 0 next edge, FSM IDLE, *_out track inputs with latency 3 after release.
